// File: rtl/wb_write_fifo_pkg.sv
// Shared constants for the Wishbone write FIFO: the user address window and the status word layout.
package wb_wfifo_pkg;

  localparam int         USER_WIN_MSB     = 14;
  localparam int         USER_WIN_LSB     = 12;
  localparam logic [2:0] USER_WIN_ID      = 3'b111;
  localparam int         STATUS_DEPTH_LSB = 16;

  // Status word: the configured depth goes in the byte at STATUS_DEPTH_LSB, and the occupancy goes in bits [7:0].
  function automatic logic [31:0] status_word(input int depth, input logic [7:0] cnt);
    logic [31:0] w;
    w = '0;
    w[STATUS_DEPTH_LSB +: 8] = depth[7:0];
    w[7:0] = cnt;
    return w;
  endfunction

endpackage

// File: rtl/wb_write_fifo_if.sv
// Bundles the Wishbone slave port, the downstream valid/ready stream and the arbiter flags of the write FIFO.
interface wb_write_fifo_if #(parameter int DW = 32);

  logic          wbs_stb_i;
  logic          wbs_cyc_i;
  logic          wbs_we_i;
  logic [3:0]    wbs_sel_i;
  logic [31:0]   wbs_adr_i;
  logic [DW-1:0] wbs_dat_i;
  logic          wbs_ack_o;
  logic [DW-1:0] wbs_dat_o;
  logic          dn_valid;
  logic [DW-1:0] dn_data;
  logic          dn_ready;
  logic          abt_full_n;
  logic          abt_empty_n;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i, dn_ready,
    input  wbs_ack_o, wbs_dat_o, dn_valid, dn_data, abt_full_n, abt_empty_n
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i, dn_ready,
    output wbs_ack_o, wbs_dat_o, dn_valid, dn_data, abt_full_n, abt_empty_n
  );

endinterface

// File: rtl/wb_write_fifo_core.sv
// DEPTH-entry FIFO storage, with pointers and an occupancy count. Reads are combinational from the head.
// A push while full and a pop while empty are both ignored, so the count stays within 0..DEPTH.
module wfifo_core #(
  parameter int DEPTH = 8,
  parameter int DW    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [DW-1:0]          din,
  output logic [DW-1:0]          dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;
  localparam cnt_t DEPTH_C = cnt_t'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  ptr_t          wr_ptr_q, wr_ptr_d;
  ptr_t          rd_ptr_q, rd_ptr_d;
  cnt_t          count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + ptr_t'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + ptr_t'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + cnt_t'(1);
      2'b01:   count_d = count_q - cnt_t'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; only the pointers determine what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/wb_write_fifo.sv
// Wishbone-slave write FIFO: buffers in-window writes for the user-side consumer, with a registered ack.
// If WB_WFIFO_STATUS_EN is defined, in-window reads are also acked and return {depth, count} status.
module wb_write_fifo #(
  parameter int DEPTH = 8,
  parameter int DW    = 32
) (
  input  logic            clk,
  input  logic            rst,
  wb_write_fifo_if.slave  bus
);

  import wb_wfifo_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic          hit, wr_req, push, full, empty;
  logic [CW-1:0] count;
  logic          ack_q, ack_d;

  assign hit    = (bus.wbs_adr_i[USER_WIN_MSB:USER_WIN_LSB] == USER_WIN_ID);
  assign wr_req = bus.wbs_stb_i & bus.wbs_cyc_i & bus.wbs_we_i & hit;
  // The full check uses the registered count, so a pop in the same cycle does not free a slot for this edge.
  assign push   = wr_req & ~ack_q & ~full;

  wfifo_core #(.DEPTH(DEPTH), .DW(DW)) u_core (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (bus.dn_ready),
    .din   (bus.wbs_dat_i),
    .dout  (bus.dn_data),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign bus.dn_valid    = ~empty;
  assign bus.abt_full_n  = ~full;
  assign bus.abt_empty_n = ~empty;
  assign bus.wbs_ack_o   = ack_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ack_q <= 1'b0;
    else     ack_q <= ack_d;
  end

`ifdef WB_WFIFO_STATUS_EN
  logic          rd_req, rd_ack;
  logic [DW-1:0] dat_o_q, dat_o_d;

  assign rd_req = bus.wbs_stb_i & bus.wbs_cyc_i & ~bus.wbs_we_i & hit;
  assign rd_ack = rd_req & ~ack_q;

  always_comb begin
    ack_d   = push | rd_ack;
    dat_o_d = '0;
    if (rd_ack) dat_o_d = DW'(status_word(DEPTH, 8'(count)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) dat_o_q <= '0;
    else     dat_o_q <= dat_o_d;
  end

  assign bus.wbs_dat_o = dat_o_q;
`else
  logic unused_count;

  always_comb begin
    ack_d = push;
  end

  assign bus.wbs_dat_o = '0;
  assign unused_count  = ^count;
`endif

  logic unused_bits;
  assign unused_bits = ^{bus.wbs_sel_i, bus.wbs_adr_i[31:USER_WIN_MSB+1], bus.wbs_adr_i[USER_WIN_LSB-1:0]};

endmodule
